// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction memory: sequential, jump and PC-relative
// branch fetch, with hold states for operator input, HALT and out-of-range fetch.
module pc_sequencer #(
   parameter int PC_WIDTH  = 32,
   parameter int MEM_DEPTH = 100,
   parameter int RESET_PC  = 0
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Jump,
   input  logic [PC_WIDTH-1:0] JumpAddr,
   input  logic                Branch,
   input  logic                BranchTaken,
   input  logic [15:0]         BranchOffset,
   input  logic                WaitInput,
   input  logic                Confirm,
   input  logic                Halt,
   output logic [PC_WIDTH-1:0] ProgramCounter,
   output logic [PC_WIDTH-1:0] LinkAddress,
   output logic                Waiting,
   output logic                Halted,
   output logic                Fault
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT_IO = 2'd1,
      ST_HALT    = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0] MEM_LIMIT = PC_WIDTH'(MEM_DEPTH);
   localparam logic [PC_WIDTH-1:0] PC_INIT   = PC_WIDTH'(RESET_PC);

   state_t              state_r;
   state_t              state_s;
   logic [PC_WIDTH-1:0] pc_next_s;
   logic [PC_WIDTH-1:0] pc_plus1_s;
   logic [PC_WIDTH-1:0] branch_target_s;
   logic [PC_WIDTH-1:0] candidate_s;
   logic                advance_s;
   logic                sync1_r;
   logic                sync2_r;
   logic                prev_r;
   logic                armed_r;
   logic                confirm_edge_s;

   // Address arithmetic shared by the next-PC mux and the link output
   always_comb begin
      pc_plus1_s      = ProgramCounter + PC_ONE;
      branch_target_s = pc_plus1_s + {{(PC_WIDTH-16){BranchOffset[15]}}, BranchOffset};
      confirm_edge_s  = sync2_r & ~prev_r;
   end

   assign LinkAddress = pc_plus1_s;

   // Next-state and next-PC selection with the RUN priority order and range check
   always_comb begin
      state_s     = state_r;
      pc_next_s   = ProgramCounter;
      candidate_s = pc_plus1_s;
      advance_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (Halt) begin
               state_s = ST_HALT;
            end else if (WaitInput) begin
               state_s = ST_WAIT_IO;
            end else begin
               advance_s = 1'b1;
               if (Jump) begin
                  candidate_s = JumpAddr;
               end else if (Branch && BranchTaken) begin
                  candidate_s = branch_target_s;
               end else begin
                  candidate_s = pc_plus1_s;
               end
            end
         end
         ST_WAIT_IO: begin
            // Only an edge seen after Confirm was low inside this wait may release it
            if (confirm_edge_s && armed_r) begin
               advance_s   = 1'b1;
               candidate_s = pc_plus1_s;
            end else begin
               state_s = ST_WAIT_IO;
            end
         end
         ST_HALT:  state_s = ST_HALT;
         ST_FAULT: state_s = ST_FAULT;
         default:  state_s = ST_FAULT;
      endcase
      if (advance_s) begin
         if (candidate_s >= MEM_LIMIT) begin
            state_s = ST_FAULT;
         end else begin
            pc_next_s = candidate_s;
            state_s   = ST_RUN;
         end
      end else begin
         pc_next_s = ProgramCounter;
      end
   end

   // PC, state and registered state-decode outputs
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r        <= ST_RUN;
         ProgramCounter <= PC_INIT;
         Waiting        <= 1'b0;
         Halted         <= 1'b0;
         Fault          <= 1'b0;
      end else begin
         state_r        <= state_s;
         ProgramCounter <= pc_next_s;
         Waiting        <= (state_s == ST_WAIT_IO);
         Halted         <= (state_s == ST_HALT);
         Fault          <= (state_s == ST_FAULT);
      end
   end

   // Confirm synchroniser, edge history and per-wait arming
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= Confirm;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         if (state_r == ST_WAIT_IO) begin
            armed_r <= armed_r | (~sync1_r & ~sync2_r);
         end else begin
            armed_r <= 1'b0;
         end
      end
   end

endmodule
